// File: rtl/home_pkg.sv
// Shared definitions for the smart-home command path: mode codes, appliance bit
// positions and the scheduler FSM encoding.
package home_pkg;

    localparam logic [3:0] MODE_LIGHT_ON   = 4'd0;
    localparam logic [3:0] MODE_LIGHT_OFF  = 4'd1;
    localparam logic [3:0] MODE_FAN_ON     = 4'd2;
    localparam logic [3:0] MODE_FAN_OFF    = 4'd3;
    localparam logic [3:0] MODE_AC_ON      = 4'd4;
    localparam logic [3:0] MODE_AC_OFF     = 4'd5;
    localparam logic [3:0] MODE_HEATER_ON  = 4'd6;
    localparam logic [3:0] MODE_HEATER_OFF = 4'd7;
    localparam logic [3:0] MODE_WASH_ON    = 4'd8;
    localparam logic [3:0] MODE_WASH_OFF   = 4'd9;
    localparam logic [3:0] MODE_ALARM_ON   = 4'd10;
    localparam logic [3:0] MODE_ALARM_OFF  = 4'd11;
    localparam logic [3:0] MODE_LAST_VALID = 4'd11;

    localparam int BIT_LIGHT       = 0;
    localparam int BIT_FAN         = 1;
    localparam int BIT_AC          = 2;
    localparam int BIT_HEATER      = 3;
    localparam int BIT_WASH        = 4;
    localparam int BIT_WATER_ALARM = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PGAP = 3'd2,
        ST_MAIN = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    // Shadow bit touched by a mode code (even = ON, odd = OFF).
    function automatic logic [2:0] mode_bit(input logic [3:0] m);
        return m[3:1];
    endfunction

endpackage

// File: rtl/home_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The pointer itself is owned by the parent.
module rr_arbiter
    import home_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);

    int w_j;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        w_j = 0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(ptr) + i) % N;
            if (!vld && req[w_j]) begin
                vld      = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/home_cmd_scheduler.sv
// Round-robin command scheduler for the smart-home controller: AC/HEATER interlock,
// relay-settling gap between strobes, and a shadow copy of appliance state.
module home_cmd_scheduler
    import home_pkg::*;
#(
    parameter int N_REQ              = 3,
    parameter int GAP                = 2,
    parameter bit SUPPRESS_REDUNDANT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_mode,
    output logic [N_REQ-1:0]     gnt,
    output logic                 ok_google,
    output logic [3:0]           mode,
    output logic                 busy,
    output logic                 cmd_err,
    output logic [5:0]           appliance_state
);

    localparam int             PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]     GAP_LD = 4'(GAP - 1);
    localparam logic [PW-1:0]  LAST   = PW'(N_REQ - 1);

    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_ptr;
    logic [3:0]     r_gap_cnt, r_cmd, r_pre, r_mode;
    logic [5:0]     r_shadow;
    logic           r_ok, r_err;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [PW-1:0]    w_arb_idx;
    logic             w_arb_vld;
    logic             w_xfer, w_err, w_noop, w_ilk;
    logic [3:0]       w_cmd, w_ilk_code;
    logic             w_ok_nxt, w_err_nxt;
    logic [3:0]       w_mode_nxt;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx),
        .vld (w_arb_vld)
    );

    assign gnt    = (r_state == ST_IDLE && !rst && w_arb_vld) ? w_arb_gnt : '0;
    assign w_xfer = |(req & gnt);
    assign w_cmd  = req_mode[4*w_arb_idx +: 4];

    // Error check first: codes above 11 would index past the shadow register.
    assign w_err      = (w_cmd > MODE_LAST_VALID);
    assign w_noop     = SUPPRESS_REDUNDANT && !w_err && (r_shadow[mode_bit(w_cmd)] == ~w_cmd[0]);
    assign w_ilk      = (w_cmd == MODE_AC_ON     && r_shadow[BIT_HEATER]) ||
                        (w_cmd == MODE_HEATER_ON && r_shadow[BIT_AC]);
    assign w_ilk_code = (w_cmd == MODE_AC_ON) ? MODE_HEATER_OFF : MODE_AC_OFF;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer && !w_err && !w_noop) w_state_nxt = w_ilk ? ST_PRE : ST_MAIN;
            ST_PRE:  w_state_nxt = (GAP > 0) ? ST_PGAP : ST_MAIN;
            ST_PGAP: if (r_gap_cnt == 4'd0) w_state_nxt = ST_MAIN;
            ST_MAIN: w_state_nxt = (GAP > 0) ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobe and code are computed for the state being entered so they register alongside it.
    always_comb begin
        w_ok_nxt   = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_MAIN);
        w_err_nxt  = (r_state == ST_IDLE) && w_xfer && w_err;
        w_mode_nxt = r_cmd;
        if (w_state_nxt == ST_PRE)    w_mode_nxt = w_ilk_code;
        else if (r_state == ST_IDLE)  w_mode_nxt = w_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_gap_cnt <= '0;
            r_cmd     <= '0;
            r_pre     <= '0;
            r_shadow  <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_mode    <= '0;
        end else begin
            r_ok  <= w_ok_nxt;
            r_err <= w_err_nxt;
            if (w_ok_nxt) r_mode <= w_mode_nxt;
            if (w_xfer) begin
                r_ptr <= (w_arb_idx == LAST) ? '0 : w_arb_idx + PW'(1);
                r_cmd <= w_cmd;
                r_pre <= w_ilk_code;
            end
            if ((r_state == ST_PRE || r_state == ST_MAIN) && GAP > 0) r_gap_cnt <= GAP_LD;
            else if (r_gap_cnt != 4'd0)                              r_gap_cnt <= r_gap_cnt - 4'd1;
            if (r_state == ST_PRE)  r_shadow[mode_bit(r_pre)] <= ~r_pre[0];
            if (r_state == ST_MAIN) r_shadow[mode_bit(r_cmd)] <= ~r_cmd[0];
        end
    end

    assign ok_google       = r_ok;
    assign mode            = r_mode;
    assign cmd_err         = r_err;
    assign busy            = (r_state != ST_IDLE);
    assign appliance_state = r_shadow;

endmodule

// File: tb/tb_home_cmd_scheduler.sv
// Directed bench for home_cmd_scheduler: table of single transactions plus
// hand-written latency, round-robin, mid-sequence reset and no-suppress sequences.
module tb_home_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [11:0] req_mode = '0;
    logic [2:0]  gnt;
    logic        ok_google, busy, cmd_err;
    logic [3:0]  mode;
    logic [5:0]  appliance_state;

    logic [2:0]  req_b = '0;
    logic [11:0] req_mode_b = '0;
    logic [2:0]  gnt_b;
    logic        ok_b, busy_b, err_b;
    logic [3:0]  mode_b;
    logic [5:0]  state_b;

    int n_pass  = 0;
    int n_total = 0;

    home_cmd_scheduler #(.N_REQ(3), .GAP(2), .SUPPRESS_REDUNDANT(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .gnt(gnt),
        .ok_google(ok_google), .mode(mode), .busy(busy), .cmd_err(cmd_err),
        .appliance_state(appliance_state)
    );

    home_cmd_scheduler #(.N_REQ(3), .GAP(2), .SUPPRESS_REDUNDANT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_mode(req_mode_b), .gnt(gnt_b),
        .ok_google(ok_b), .mode(mode_b), .busy(busy_b), .cmd_err(err_b),
        .appliance_state(state_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [11:0] md;
        logic [2:0]  egnt;
        int          nerr;
        int          ncode;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [5:0]  est;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int nok, nerr;
        logic [3:0] cc0, cc1;
        int gi[4], gc[4];
        int ng, onehot_bad;

        // {req, {m2,m1,m0}, gnt, nerr, ncode, c0, c1, final shadow}
        tv[0]  = '{3'b001, {4'd0, 4'd0, 4'd0},  3'b001, 0, 1, 4'd0,  4'd0, 6'b000001};
        tv[1]  = '{3'b010, {4'd0, 4'd6, 4'd0},  3'b010, 0, 1, 4'd6,  4'd0, 6'b001001};
        tv[2]  = '{3'b100, {4'd4, 4'd0, 4'd0},  3'b100, 0, 2, 4'd7,  4'd4, 6'b000101};
        tv[3]  = '{3'b001, {4'd0, 4'd0, 4'd6},  3'b001, 0, 2, 4'd5,  4'd6, 6'b001001};
        tv[4]  = '{3'b010, {4'd0, 4'd13, 4'd0}, 3'b010, 1, 0, 4'd0,  4'd0, 6'b001001};
        tv[5]  = '{3'b100, {4'd0, 4'd0, 4'd0},  3'b100, 0, 0, 4'd0,  4'd0, 6'b001001};
        tv[6]  = '{3'b011, {4'd0, 4'd9, 4'd2},  3'b001, 0, 1, 4'd2,  4'd0, 6'b001011};
        tv[7]  = '{3'b101, {4'd11, 4'd0, 4'd1}, 3'b100, 0, 0, 4'd0,  4'd0, 6'b001011};
        tv[8]  = '{3'b110, {4'd8, 4'd10, 4'd0}, 3'b010, 0, 1, 4'd10, 4'd0, 6'b101011};
        tv[9]  = '{3'b001, {4'd0, 4'd0, 4'd3},  3'b001, 0, 1, 4'd3,  4'd0, 6'b101001};
        tv[10] = '{3'b001, {4'd0, 4'd0, 4'd15}, 3'b001, 1, 0, 4'd0,  4'd0, 6'b101001};

        // Reset state and plain-command latency
        do_reset();
        chk("rst_ok", ok_google, 0);
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_state", appliance_state, 0);
        chk("rst_gnt", gnt, 0);
        req = 3'b001; req_mode = '0;
        #1 chk("lat_gnt_t", gnt, 3'b001);
        @(negedge clk); req = '0;
        chk("lat_ok_t1", ok_google, 1);
        chk("lat_mode_t1", mode, 0);
        chk("lat_busy_t1", busy, 1);
        @(negedge clk);
        chk("lat_ok_t2", ok_google, 0);
        chk("lat_state_t2", appliance_state, 6'b000001);
        @(negedge clk);
        chk("lat_busy_t3", busy, 1);
        @(negedge clk);
        chk("lat_busy_t4", busy, 0);

        // Round robin with all three held
        do_reset();
        req = 3'b111; req_mode = {4'd4, 4'd2, 4'd0};
        ng = 0; onehot_bad = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (!$onehot0(gnt)) onehot_bad++;
            if (gnt != 0 && ng < 4) begin
                gi[ng] = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : 2;
                gc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        req = '0;
        chk("rr_count", ng, 4);
        chk("rr_onehot", onehot_bad, 0);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr_idx%0d", k), gi[k], (k == 3) ? 0 : k);
            if (k > 0) chk($sformatf("rr_gap%0d", k), gc[k] - gc[k-1], 4);
        end

        // Table-driven single transactions
        do_reset();
        for (int k = 0; k < 11; k++) begin
            wait_idle();
            @(negedge clk);
            req = tv[k].req; req_mode = tv[k].md;
            #1 chk($sformatf("v%0d_gnt", k), gnt, tv[k].egnt);
            @(negedge clk); req = '0;
            nok = 0; nerr = 0; cc0 = 'x; cc1 = 'x;
            for (int c = 0; c < 7; c++) begin
                if (ok_google) begin
                    if (nok == 0) cc0 = mode;
                    else if (nok == 1) cc1 = mode;
                    nok++;
                end
                if (cmd_err) nerr++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_ncode", k), nok, tv[k].ncode);
            chk($sformatf("v%0d_nerr", k), nerr, tv[k].nerr);
            if (tv[k].ncode >= 1) chk($sformatf("v%0d_c0", k), cc0, tv[k].c0);
            if (tv[k].ncode == 2) chk($sformatf("v%0d_c1", k), cc1, tv[k].c1);
            if (tv[k].ncode >= 1)
                chk($sformatf("v%0d_mode_hold", k), mode, (tv[k].ncode == 2) ? tv[k].c1 : tv[k].c0);
            chk($sformatf("v%0d_state", k), appliance_state, tv[k].est);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end

        // Reset during the PGAP of an interlocked AC_ON
        do_reset();
        req = 3'b001; req_mode = {4'd0, 4'd0, 4'd6};
        @(negedge clk); req = '0;
        repeat (4) @(negedge clk);
        wait_idle();
        chk("ilk_heater_on", appliance_state, 6'b001000);
        req = 3'b010; req_mode = {4'd0, 4'd4, 4'd0};
        #1 chk("ilk_gnt", gnt, 3'b010);
        @(negedge clk); req = '0;
        chk("ilk_pre_ok", ok_google, 1);
        chk("ilk_pre_mode", mode, 7);
        @(negedge clk);
        chk("ilk_pgap_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("ilk_rst_busy", busy, 0);
        chk("ilk_rst_state", appliance_state, 0);
        nok = 0;
        for (int c = 0; c < 6; c++) begin
            if (ok_google) nok++;
            @(negedge clk);
        end
        chk("ilk_rst_no_strobe", nok, 0);
        chk("ilk_rst_state_end", appliance_state, 0);

        // Redundant LIGHT_ON without suppression still issues a strobe
        do_reset();
        req_b = 3'b001; req_mode_b = '0;
        #1 chk("ns_gnt1", gnt_b, 3'b001);
        @(negedge clk); req_b = '0;
        chk("ns_ok1", ok_b, 1);
        repeat (4) @(negedge clk);
        chk("ns_busy", busy_b, 0);
        chk("ns_state1", state_b, 6'b000001);
        req_b = 3'b001;
        #1 chk("ns_gnt2", gnt_b, 3'b001);
        @(negedge clk); req_b = '0;
        chk("ns_ok2", ok_b, 1);
        chk("ns_mode2", mode_b, 0);
        repeat (4) @(negedge clk);
        chk("ns_state2", state_b, 6'b000001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
